// File: rtl/button_counter.sv
// Debounced up/down push-button counter feeding the 7-segment display's binary_in.
// Each button: 2-flop synchroniser, debouncer, IDLE/HOLD/REPEAT auto-repeat FSM.
module button_counter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 20000000,
    parameter int MAX_VALUE       = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] count,
    output logic       step_up,
    output logic       step_down
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TM_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] HOLD_LAST   = TM_W'(HOLD_CYCLES - 1);
    localparam logic [TM_W-1:0] REPEAT_LAST = TM_W'(REPEAT_CYCLES - 1);
    localparam logic [3:0]      MAX_CNT     = 4'(MAX_VALUE);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Index 0 is the up button, index 1 the down button throughout.
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      db;
    logic [DB_W-1:0] db_cnt    [2];
    logic [1:0]      state     [2];
    logic [1:0]      state_nxt [2];
    logic [TM_W-1:0] timer     [2];
    logic [TM_W-1:0] timer_nxt [2];
    logic [1:0]      step;

    // NOTE: flops are written with <= so every register samples pre-edge values,
    // regardless of the order in which always blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn_down, btn_up};
            sync2 <= sync1;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            timer_nxt[i] = timer[i] + TM_W'(1);
            step[i]      = 1'b0;
            case (state[i])
                ST_IDLE: begin
                    timer_nxt[i] = '0;
                    if (db[i]) begin
                        state_nxt[i] = ST_HOLD;
                        step[i]      = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!db[i]) begin
                        state_nxt[i] = ST_IDLE;
                        timer_nxt[i] = '0;
                    end else if (timer[i] == HOLD_LAST) begin
                        state_nxt[i] = ST_REPEAT;
                        timer_nxt[i] = '0;
                        step[i]      = 1'b1;
                    end
                end
                ST_REPEAT: begin
                    // Release wins over a repeat step falling due in the same cycle.
                    if (!db[i]) begin
                        state_nxt[i] = ST_IDLE;
                        timer_nxt[i] = '0;
                    end else if (timer[i] == REPEAT_LAST) begin
                        timer_nxt[i] = '0;
                        step[i]      = 1'b1;
                    end
                end
                default: begin
                    state_nxt[i] = ST_IDLE;
                    timer_nxt[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= ST_IDLE;
                timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_nxt[i];
                timer[i] <= timer_nxt[i];
            end
        end
    end

    // Simultaneous up and down steps cancel in the count but both pulses still fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
        end else begin
            step_up   <= step[0];
            step_down <= step[1];
            case (step)
                2'b01:   count <= (count == MAX_CNT) ? 4'd0 : count + 4'd1;
                2'b10:   count <= (count == 4'd0) ? MAX_CNT : count - 4'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_button_counter.sv
// Self-checking bench for button_counter: vector table, timing sequences and
// randomized presses against a cycle-level behavioural model of two instances.
module tb_button_counter;

    localparam int DEB  = 4;
    localparam int HLD  = 20;
    localparam int REP  = 8;
    localparam int MAX0 = 15;
    localparam int MAX1 = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn_u = '0;
    logic [1:0] btn_d = '0;
    logic [3:0] count0, count1;
    logic [1:0] sup, sdn;

    int n_checks = 0;
    int n_errors = 0;
    int ups0 = 0;
    int downs0 = 0;

    always #5 clk = ~clk;

    button_counter #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HLD), .REPEAT_CYCLES(REP),
                     .MAX_VALUE(MAX0)) dut0 (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_u[0]), .btn_down(btn_d[0]),
        .count(count0), .step_up(sup[0]), .step_down(sdn[0]));

    button_counter #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HLD), .REPEAT_CYCLES(REP),
                     .MAX_VALUE(MAX1)) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_u[1]), .btn_down(btn_d[1]),
        .count(count1), .step_up(sup[1]), .step_down(sdn[1]));

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per button: synchroniser pipeline, debounced level (flips after DEB consecutive
    // differing samples), and press age in edges since the press step.
    bit m_s1   [2][2];
    bit m_s2   [2][2];
    bit m_db   [2][2];
    int m_run  [2][2];
    bit m_held [2][2];
    int m_age  [2][2];
    bit m_step [2][2];
    int m_count[2];

    task automatic model_edge();
        int mx;
        int net;
        bit raw;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_count[k] = 0;
                for (int b = 0; b < 2; b++) begin
                    m_s1[k][b] = 0; m_s2[k][b] = 0; m_db[k][b] = 0; m_run[k][b] = 0;
                    m_held[k][b] = 0; m_age[k][b] = 0; m_step[k][b] = 0;
                end
            end
            return;
        end
        for (int k = 0; k < 2; k++) begin
            mx = (k == 0) ? MAX0 : MAX1;
            for (int b = 0; b < 2; b++) begin
                raw = (b == 0) ? btn_u[k] : btn_d[k];
                m_step[k][b] = 0;
                if (!m_held[k][b]) begin
                    if (m_db[k][b]) begin
                        m_step[k][b] = 1; m_held[k][b] = 1; m_age[k][b] = 0;
                    end
                end else if (!m_db[k][b]) begin
                    m_held[k][b] = 0;
                end else begin
                    m_age[k][b]++;
                    if (m_age[k][b] == HLD || (m_age[k][b] > HLD && (m_age[k][b] - HLD) % REP == 0))
                        m_step[k][b] = 1;
                end
                if (m_s2[k][b] != m_db[k][b]) begin
                    m_run[k][b]++;
                    if (m_run[k][b] == DEB) begin
                        m_db[k][b] = m_s2[k][b];
                        m_run[k][b] = 0;
                    end
                end else begin
                    m_run[k][b] = 0;
                end
                m_s2[k][b] = m_s1[k][b];
                m_s1[k][b] = raw;
            end
            net = int'(m_step[k][0]) - int'(m_step[k][1]);
            m_count[k] = (m_count[k] + net + mx + 1) % (mx + 1);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_edge();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("model count0", int'(count0), m_count[0]);
            check("model step_up0", int'(sup[0]), int'(m_step[0][0]));
            check("model step_down0", int'(sdn[0]), int'(m_step[0][1]));
            check("model count1", int'(count1), m_count[1]);
            check("model step_up1", int'(sup[1]), int'(m_step[1][0]));
            check("model step_down1", int'(sdn[1]), int'(m_step[1][1]));
            if (sup[0]) ups0++;
            if (sdn[0]) downs0++;
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        string name;
        bit    up;
        bit    down;
        int    cycles;
        int    exp_count;
        int    exp_ups;
        int    exp_downs;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string n, input bit u, input bit d, input int c,
                           input int ec, input int eu, input int ed);
        vec_t v;
        v.name = n; v.up = u; v.down = d; v.cycles = c;
        v.exp_count = ec; v.exp_ups = eu; v.exp_downs = ed;
        vecs.push_back(v);
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn_u = '0;
        btn_d = '0;
        edges(3);
        rst_n = 1'b1;
        edges(2);
    endtask

    task automatic press(input int k, input bit u, input bit d, input int n, input int gap);
        btn_u[k] = u;
        btn_d[k] = d;
        edges(n);
        btn_u[k] = 1'b0;
        btn_d[k] = 1'b0;
        edges(gap);
    endtask

    int hold_left [2][2];

    initial begin
        // Expected results derived by hand: press step at edge 7, repeat at 27, 35, ...;
        // the debounced level lags release by 5 edges so a due step can still land.
        add_vec("clean up",        1, 0, 10,  1, 1, 0);
        add_vec("down to zero",    0, 1, 10,  0, 0, 1);
        add_vec("down wrap",       0, 1, 10, 15, 0, 1);
        add_vec("up wrap",         1, 0, 10,  0, 1, 0);
        add_vec("both cancel",     1, 1, 10,  0, 1, 1);
        add_vec("glitch 3 cycles", 1, 0,  3,  0, 0, 0);
        add_vec("min press 4",     1, 0,  4,  1, 1, 0);
        add_vec("release wins",    1, 0, 20,  2, 1, 0);
        add_vec("one repeat",      1, 0, 21,  4, 2, 0);
        add_vec("two repeats",     1, 0, 30,  7, 3, 0);

        do_reset();
        check("reset count0", int'(count0), 0);
        check("reset step_up0", int'(sup[0]), 0);
        check("reset step_down0", int'(sdn[0]), 0);

        foreach (vecs[i]) begin
            ups0 = 0;
            downs0 = 0;
            press(0, vecs[i].up, vecs[i].down, vecs[i].cycles, 15);
            check({vecs[i].name, " count"}, int'(count0), vecs[i].exp_count);
            check({vecs[i].name, " ups"}, ups0, vecs[i].exp_ups);
            check({vecs[i].name, " downs"}, downs0, vecs[i].exp_downs);
        end

        // Clean press timing from 0: nothing at edge 6, step exactly at edge 7.
        do_reset();
        ups0 = 0;
        btn_u[0] = 1'b1;
        edges(6);
        check("press edge6 count", int'(count0), 0);
        check("press edge6 step_up", int'(sup[0]), 0);
        edges(1);
        check("press edge7 count", int'(count0), 1);
        check("press edge7 step_up", int'(sup[0]), 1);
        edges(1);
        check("press edge8 step_up", int'(sup[0]), 0);
        edges(2);
        btn_u[0] = 1'b0;
        edges(30);
        check("press final count", int'(count0), 1);
        check("press pulse total", ups0, 1);

        // Bounce on the down button never reaches the debounced level.
        downs0 = 0;
        btn_d[0] = 1'b1; edges(1);
        btn_d[0] = 1'b0; edges(1);
        btn_d[0] = 1'b1; edges(2);
        btn_d[0] = 1'b0; edges(25);
        check("bounce count", int'(count0), 1);
        check("bounce downs", downs0, 0);

        // Auto-repeat: steps at edges 7, 27, 35, 43 while held for 50 cycles.
        do_reset();
        btn_u[0] = 1'b1;
        edges(42);
        check("repeat edge42 count", int'(count0), 3);
        edges(1);
        check("repeat edge43 count", int'(count0), 4);
        check("repeat edge43 step_up", int'(sup[0]), 1);
        edges(7);
        check("repeat edge50 count", int'(count0), 4);
        btn_u[0] = 1'b0;
        edges(40);
        // The step due at edge 51 still lands: the debounced level falls only at edge 56.
        check("repeat after release", int'(count0), 5);

        // Simultaneous press at count 5.
        btn_u[0] = 1'b1;
        btn_d[0] = 1'b1;
        edges(7);
        check("simul step_up", int'(sup[0]), 1);
        check("simul step_down", int'(sdn[0]), 1);
        check("simul count", int'(count0), 5);
        edges(3);
        btn_u[0] = 1'b0;
        btn_d[0] = 1'b0;
        edges(15);

        // Reset mid-hold with the button still held, then a full debounce.
        btn_u[0] = 1'b1;
        edges(15);
        check("midhold pre-reset count", int'(count0), 6);
        rst_n = 1'b0;
        #1;
        check("midhold reset count", int'(count0), 0);
        check("midhold reset step_up", int'(sup[0]), 0);
        edges(3);
        rst_n = 1'b1;
        edges(6);
        check("post-reset edge6 count", int'(count0), 0);
        edges(1);
        check("post-reset edge7 count", int'(count0), 1);
        check("post-reset edge7 step_up", int'(sup[0]), 1);
        btn_u[0] = 1'b0;
        edges(15);

        // MAX_VALUE = 9 instance wraps at 9.
        for (int p = 0; p < 9; p++) press(1, 1, 0, 5, 15);
        check("max9 count at 9", int'(count1), 9);
        press(1, 1, 0, 5, 15);
        check("max9 up wrap", int'(count1), 0);
        press(1, 0, 1, 5, 15);
        check("max9 down wrap", int'(count1), 9);

        // Randomized segments on all four buttons, checked cycle by cycle.
        for (int k = 0; k < 2; k++)
            for (int b = 0; b < 2; b++) hold_left[k][b] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                for (int b = 0; b < 2; b++) begin
                    if (hold_left[k][b] == 0) begin
                        hold_left[k][b] = int'($urandom_range(1, 40));
                        if (b == 0) btn_u[k] = 1'($urandom_range(0, 1));
                        else        btn_d[k] = 1'($urandom_range(0, 1));
                    end
                    hold_left[k][b]--;
                end
            end
        end
        btn_u = '0;
        btn_d = '0;
        edges(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
